// File: rtl/inst_queue_pkg.sv
// Purpose: shared types and constants for the instruction fetch queue.
//   PC / REG_WIDTH : 32-bit address and instruction words
//   iq_entry_t     : one stored {pc, inst} pair
//   iq_ptr_t       : read/write pointer, wraps modulo IQ_DEPTH
package iq_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned IQ_DEPTH = 16;
  localparam int unsigned FETCH_W  = 4;
  localparam int unsigned ISSUE_W  = 2;

  typedef logic [XLEN-1:0] PC;
  typedef logic [XLEN-1:0] REG_WIDTH;

  typedef struct packed {
    PC        pc;
    REG_WIDTH inst;
  } iq_entry_t;

  typedef logic [$clog2(IQ_DEPTH)-1:0] iq_ptr_t;

endpackage

// File: rtl/inst_queue_if.sv
// Purpose: fetch-side and decode-side signals of the instruction queue.
//   master : fetch/decode side (drives flush, fetch bundle, deq_cnt)
//   slave  : queue side (drives in_ready and the issue window)
interface inst_queue_if;
  import iq_pkg::*;

  logic                      flush;
  logic                      in_valid;
  PC                         in_pc;
  REG_WIDTH [FETCH_W-1:0]    in_inst;
  logic [2:0]                in_cnt;
  logic                      in_ready;
  logic [ISSUE_W-1:0]        out_valid;
  PC        [ISSUE_W-1:0]    out_pc;
  REG_WIDTH [ISSUE_W-1:0]    out_inst;
  logic [1:0]                deq_cnt;

  modport master (
    output flush, in_valid, in_pc, in_inst, in_cnt, deq_cnt,
    input  in_ready, out_valid, out_pc, out_inst
  );

  modport slave (
    input  flush, in_valid, in_pc, in_inst, in_cnt, deq_cnt,
    output in_ready, out_valid, out_pc, out_inst
  );

endinterface

// File: rtl/inst_queue.sv
// Purpose: circular instruction fetch queue between icache fetch and decode.
//   clk, rst_n : clock, async active-low reset
//   bus        : inst_queue_if.slave -- fetch bundle in (up to FETCH_W),
//                in_ready, ISSUE_W oldest entries out, deq_cnt, flush
module inst_queue
  import iq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  inst_queue_if.slave bus
);

  localparam int unsigned PTR_W  = $clog2(IQ_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned SLOT_W = $clog2(FETCH_W);

  iq_ptr_t             r_rptr;
  iq_ptr_t             r_wptr;
  logic [CNT_W-1:0]    r_count;
  iq_entry_t           r_mem [IQ_DEPTH];

  logic                w_in_ready;
  logic                w_push;
  logic [CNT_W-1:0]    w_in_cnt;
  logic [CNT_W-1:0]    w_deq_cnt;
  logic [CNT_W-1:0]    w_push_cnt;
  logic [CNT_W-1:0]    w_pop;
  logic [CNT_W-1:0]    w_count_next;
  iq_ptr_t             w_off   [IQ_DEPTH];
  logic [IQ_DEPTH-1:0] w_we;
  iq_entry_t           w_wdata [IQ_DEPTH];
  iq_ptr_t             w_ridx  [ISSUE_W];

  // Accept only when a full bundle is guaranteed to fit.
  assign w_in_ready   = (r_count <= CNT_W'(IQ_DEPTH - FETCH_W));
  assign w_push       = bus.in_valid & w_in_ready & ~bus.flush;
  assign w_in_cnt     = CNT_W'(bus.in_cnt);
  assign w_deq_cnt    = CNT_W'(bus.deq_cnt);
  assign w_push_cnt   = w_push ? w_in_cnt : '0;
  // Over-consumption by decode is clamped to what is actually held.
  assign w_pop        = bus.flush ? '0 : ((w_deq_cnt > r_count) ? r_count : w_deq_cnt);
  assign w_count_next = r_count + w_push_cnt - w_pop;

  assign bus.in_ready = w_in_ready;

  // Per-entry write enable: distance from wptr (mod DEPTH) selects the bundle slot.
  always_comb begin
    for (int unsigned e = 0; e < IQ_DEPTH; e++) begin
      w_off[e]         = iq_ptr_t'(e) - r_wptr;
      w_we[e]          = w_push && (CNT_W'(w_off[e]) < w_in_cnt);
      w_wdata[e].pc    = bus.in_pc + (PC'(w_off[e]) << 2);
      w_wdata[e].inst  = bus.in_inst[w_off[e][SLOT_W-1:0]];
    end
  end

  // Storage array: written only, never reset.
  always_ff @(posedge clk) begin
    for (int unsigned e = 0; e < IQ_DEPTH; e++) begin
      if (w_we[e]) begin
        r_mem[e] <= w_wdata[e];
      end
    end
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else if (bus.flush) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      r_rptr  <= r_rptr + iq_ptr_t'(w_pop);
      r_wptr  <= r_wptr + iq_ptr_t'(w_push_cnt);
      r_count <= w_count_next;
    end
  end

  // Issue window: oldest ISSUE_W entries, zeroed where not occupied.
  always_comb begin
    bus.out_valid = '0;
    bus.out_pc    = '0;
    bus.out_inst  = '0;
    for (int unsigned i = 0; i < ISSUE_W; i++) begin
      w_ridx[i] = r_rptr + iq_ptr_t'(i);
      if (r_count > CNT_W'(i)) begin
        bus.out_valid[i] = 1'b1;
        bus.out_pc[i]    = r_mem[w_ridx[i]].pc;
        bus.out_inst[i]  = r_mem[w_ridx[i]].inst;
      end
    end
  end

  a_deq_le_count: assert property (@(posedge clk) disable iff (!rst_n) w_deq_cnt <= r_count);
  a_count_le_depth: assert property (@(posedge clk) disable iff (!rst_n) r_count <= CNT_W'(IQ_DEPTH));
  a_in_cnt_le_fetch: assert property (@(posedge clk) disable iff (!rst_n) w_in_cnt <= CNT_W'(FETCH_W));

endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue: directed scenarios plus randomized traffic against a
// queue-of-entries reference model.
module tb_inst_queue;
  import iq_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  inst_queue_if q_if();
  inst_queue dut (.clk(clk), .rst_n(rst_n), .bus(q_if));

  int checks = 0;
  int errors = 0;

  logic [63:0]       mq[$];
  logic              e_ready;
  logic [1:0]        e_valid;
  logic [1:0][31:0]  e_pc;
  logic [1:0][31:0]  e_inst;

  function automatic void calc_exp();
    e_ready = (mq.size() <= (IQ_DEPTH - FETCH_W));
    e_valid = '0;
    e_pc    = '0;
    e_inst  = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      if (i < mq.size()) begin
        e_valid[i] = 1'b1;
        e_pc[i]    = mq[i][63:32];
        e_inst[i]  = mq[i][31:0];
      end
    end
  endfunction

  task automatic drive(input logic v, input logic [2:0] n, input logic [31:0] pc,
                       input logic [1:0] deq, input logic fl);
    q_if.in_valid = v;
    q_if.in_cnt   = n;
    q_if.in_pc    = pc;
    q_if.deq_cnt  = deq;
    q_if.flush    = fl;
    for (int k = 0; k < FETCH_W; k++) q_if.in_inst[k] = $urandom;
  endtask

  // One clock: apply the reference rules to the inputs seen at the edge.
  task automatic cycle();
    int n;
    int p;
    bit rdy;
    @(posedge clk);
    if (q_if.flush) begin
      mq.delete();
    end else begin
      n   = mq.size();
      rdy = (n <= (IQ_DEPTH - FETCH_W));
      p   = (int'(q_if.deq_cnt) > n) ? n : int'(q_if.deq_cnt);
      repeat (p) void'(mq.pop_front());
      if (q_if.in_valid && rdy) begin
        for (int k = 0; k < int'(q_if.in_cnt); k++)
          mq.push_back({q_if.in_pc + 32'(4 * k), q_if.in_inst[k]});
      end
    end
    #1;
    calc_exp();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 3'd0, 32'h0, 2'd0, 1'b0);
    mq.delete();
    #3;
    checks++;
    if (q_if.in_ready !== 1'b1 || q_if.out_valid !== 2'b00 || q_if.out_pc !== '0 || q_if.out_inst !== '0) begin
      errors++;
      $display("FAIL reset: got rdy=%b v=%b pc=%h inst=%h, expected rdy=1 v=00 pc=0 inst=0",
               q_if.in_ready, q_if.out_valid, q_if.out_pc, q_if.out_inst);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    drive(1'b1, 3'd4, 32'h0, 2'd0, 1'b0);
    q_if.in_inst[0] = 32'h34010001;
    q_if.in_inst[1] = 32'h34020002;
    q_if.in_inst[2] = 32'h34030003;
    q_if.in_inst[3] = 32'h24040000;
    cycle();
    drive(1'b0, 3'd0, 32'h0, 2'd2, 1'b0);
    checks++;
    if (q_if.out_valid !== 2'b11 || q_if.out_pc[0] !== 32'h0 || q_if.out_pc[1] !== 32'h4 ||
        q_if.out_inst[0] !== 32'h34010001 || q_if.out_inst[1] !== 32'h34020002) begin
      errors++;
      $display("FAIL basic_push: got v=%b pc=%h inst=%h, expected v=11 pc=00000004_00000000 inst=34020002_34010001",
               q_if.out_valid, q_if.out_pc, q_if.out_inst);
    end
    cycle();
    checks++;
    if (q_if.out_valid !== 2'b11 || q_if.out_pc[0] !== 32'h8 || q_if.out_pc[1] !== 32'hC ||
        q_if.out_inst[0] !== 32'h34030003 || q_if.out_inst[1] !== 32'h24040000) begin
      errors++;
      $display("FAIL basic_deq1: got v=%b pc=%h inst=%h, expected v=11 pc=0000000c_00000008",
               q_if.out_valid, q_if.out_pc, q_if.out_inst);
    end
    cycle();
    drive(1'b0, 3'd0, 32'h0, 2'd0, 1'b0);
    checks++;
    if (q_if.out_valid !== 2'b00 || q_if.out_pc !== '0 || q_if.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_empty: got v=%b pc=%h rdy=%b, expected v=00 pc=0 rdy=1",
               q_if.out_valid, q_if.out_pc, q_if.in_ready);
    end
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while (mq.size() > 0 && guard < 2 * IQ_DEPTH) begin
      drive(1'b0, 3'd0, 32'h0, 2'((mq.size() >= 2) ? 2 : mq.size()), 1'b0);
      cycle();
      guard++;
      checks++;
      if (q_if.in_ready !== e_ready || q_if.out_valid !== e_valid || q_if.out_pc !== e_pc || q_if.out_inst !== e_inst) begin
        errors++;
        $display("FAIL %s_drain: got rdy=%b v=%b pc=%h inst=%h, expected rdy=%b v=%b pc=%h inst=%h",
                 name, q_if.in_ready, q_if.out_valid, q_if.out_pc, q_if.out_inst, e_ready, e_valid, e_pc, e_inst);
      end
    end
    drive(1'b0, 3'd0, 32'h0, 2'd0, 1'b0);
  endtask

  task automatic test_fill();
    drive(1'b0, 3'd0, 32'h0, 2'd0, 1'b1);
    cycle();
    for (int b = 0; b < 4; b++) begin
      drive(1'b1, 3'd4, 32'h1000 + 32'(16 * b), 2'd0, 1'b0);
      cycle();
      checks++;
      if (q_if.in_ready !== e_ready || q_if.out_valid !== e_valid || q_if.out_pc !== e_pc || q_if.out_inst !== e_inst) begin
        errors++;
        $display("FAIL fill_push%0d: got rdy=%b v=%b pc=%h inst=%h, expected rdy=%b v=%b pc=%h inst=%h",
                 b, q_if.in_ready, q_if.out_valid, q_if.out_pc, q_if.out_inst, e_ready, e_valid, e_pc, e_inst);
      end
    end
    checks++;
    if (q_if.in_ready !== 1'b0 || q_if.out_valid !== 2'b11) begin
      errors++;
      $display("FAIL fill_full: got rdy=%b v=%b, expected rdy=0 v=11", q_if.in_ready, q_if.out_valid);
    end
    // Held fetch while full must be dropped.
    drive(1'b1, 3'd4, 32'hDEAD0000, 2'd0, 1'b0);
    cycle();
    q_if.deq_cnt = 2'd2;
    cycle();
    cycle();
    drive(1'b0, 3'd0, 32'h0, 2'd0, 1'b0);
    checks++;
    if (q_if.in_ready !== 1'b1 || e_ready !== 1'b1 || q_if.out_pc !== e_pc || q_if.out_inst !== e_inst) begin
      errors++;
      $display("FAIL fill_reopen: got rdy=%b pc=%h, expected rdy=1 pc=%h", q_if.in_ready, q_if.out_pc, e_pc);
    end
    drain("fill");
  endtask

  task automatic test_wrap();
    int sizes[4] = '{4, 4, 4, 2};
    drive(1'b0, 3'd0, 32'h0, 2'd0, 1'b1);
    cycle();
    foreach (sizes[b]) begin
      drive(1'b1, 3'(sizes[b]), 32'h2000 + 32'(16 * b), 2'd0, 1'b0);
      cycle();
    end
    drain("wrap_pre");
    drive(1'b1, 3'd4, 32'h100, 2'd0, 1'b0);
    cycle();
    for (int j = 0; j < 2; j++) begin
      drive(1'b0, 3'd0, 32'h0, 2'd2, 1'b0);
      checks++;
      if (q_if.out_valid !== 2'b11 || q_if.out_pc[0] !== 32'h100 + 32'(8 * j) ||
          q_if.out_pc[1] !== 32'h104 + 32'(8 * j) || q_if.out_inst !== e_inst) begin
        errors++;
        $display("FAIL wrap_order%0d: got v=%b pc=%h inst=%h, expected v=11 pc0=%h inst=%h",
                 j, q_if.out_valid, q_if.out_pc, q_if.out_inst, 32'h100 + 32'(8 * j), e_inst);
      end
      cycle();
    end
    drive(1'b0, 3'd0, 32'h0, 2'd0, 1'b0);
    checks++;
    if (q_if.out_valid !== 2'b00) begin
      errors++;
      $display("FAIL wrap_empty: got v=%b, expected v=00", q_if.out_valid);
    end
  endtask

  task automatic test_simul();
    drive(1'b0, 3'd0, 32'h0, 2'd0, 1'b1);
    cycle();
    drive(1'b1, 3'd2, 32'h3000, 2'd0, 1'b0);
    cycle();
    drive(1'b1, 3'd3, 32'h4000, 2'd2, 1'b0);
    cycle();
    drive(1'b0, 3'd0, 32'h0, 2'd2, 1'b0);
    checks++;
    if (q_if.out_valid !== 2'b11 || q_if.out_pc[0] !== 32'h4000 || q_if.out_pc[1] !== 32'h4004) begin
      errors++;
      $display("FAIL simul_first: got v=%b pc=%h, expected v=11 pc=00004004_00004000", q_if.out_valid, q_if.out_pc);
    end
    cycle();
    drive(1'b0, 3'd0, 32'h0, 2'd1, 1'b0);
    checks++;
    if (q_if.out_valid !== 2'b01 || q_if.out_pc[0] !== 32'h4008 || q_if.out_pc[1] !== 32'h0 || q_if.out_inst !== e_inst) begin
      errors++;
      $display("FAIL simul_count3: got v=%b pc=%h, expected v=01 pc=00000000_00004008", q_if.out_valid, q_if.out_pc);
    end
    cycle();
    drive(1'b0, 3'd0, 32'h0, 2'd0, 1'b0);
  endtask

  task automatic test_flush();
    int sizes[3] = '{4, 4, 1};
    foreach (sizes[b]) begin
      drive(1'b1, 3'(sizes[b]), 32'h5000 + 32'(16 * b), 2'd0, 1'b0);
      cycle();
    end
    drive(1'b1, 3'd4, 32'h6000, 2'd2, 1'b1);
    cycle();
    drive(1'b0, 3'd0, 32'h0, 2'd0, 1'b0);
    checks++;
    if (q_if.out_valid !== 2'b00 || q_if.in_ready !== 1'b1 || q_if.out_pc !== '0) begin
      errors++;
      $display("FAIL flush_clear: got v=%b rdy=%b pc=%h, expected v=00 rdy=1 pc=0",
               q_if.out_valid, q_if.in_ready, q_if.out_pc);
    end
    cycle();
    drive(1'b1, 3'd1, 32'h7000, 2'd0, 1'b0);
    cycle();
    drive(1'b0, 3'd0, 32'h0, 2'd0, 1'b0);
    checks++;
    if (q_if.out_valid !== 2'b01 || q_if.out_pc[0] !== 32'h7000 || q_if.out_inst !== e_inst) begin
      errors++;
      $display("FAIL flush_refill: got v=%b pc=%h, expected v=01 pc0=00007000", q_if.out_valid, q_if.out_pc);
    end
    drain("flush");
  endtask

  task automatic test_random();
    int mx;
    for (int c = 0; c < 400; c++) begin
      mx = (mq.size() >= 2) ? 2 : mq.size();
      drive(($urandom % 4) != 0, 3'($urandom % 5), $urandom & 32'hFFFF_FFFC,
            2'($urandom_range(mx, 0)), ($urandom % 32) == 0);
      cycle();
      checks++;
      if (q_if.in_ready !== e_ready || q_if.out_valid !== e_valid || q_if.out_pc !== e_pc || q_if.out_inst !== e_inst) begin
        errors++;
        $display("FAIL random%0d: got rdy=%b v=%b pc=%h inst=%h, expected rdy=%b v=%b pc=%h inst=%h",
                 c, q_if.in_ready, q_if.out_valid, q_if.out_pc, q_if.out_inst, e_ready, e_valid, e_pc, e_inst);
      end
    end
    drive(1'b0, 3'd0, 32'h0, 2'd0, 1'b0);
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 3'd4, 32'h8000, 2'd0, 1'b0);
    cycle();
    drive(1'b0, 3'd0, 32'h0, 2'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    mq.delete();
    #1;
    checks++;
    if (q_if.out_valid !== 2'b00 || q_if.in_ready !== 1'b1 || q_if.out_pc !== '0 || q_if.out_inst !== '0) begin
      errors++;
      $display("FAIL reset_mid: got v=%b rdy=%b pc=%h, expected v=00 rdy=1 pc=0",
               q_if.out_valid, q_if.in_ready, q_if.out_pc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    checks++;
    if (q_if.in_ready !== e_ready || q_if.out_valid !== e_valid || q_if.out_pc !== e_pc) begin
      errors++;
      $display("FAIL reset_after: got rdy=%b v=%b pc=%h, expected rdy=%b v=%b pc=%h",
               q_if.in_ready, q_if.out_valid, q_if.out_pc, e_ready, e_valid, e_pc);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_wrap();
    test_simul();
    test_flush();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
